// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl
// Decode-stage branch sequencer. A branch whose condition flags are still
// being produced by the instruction in EX is held (stall) until the flags
// settle or a wait budget runs out. Resolved branches either redirect fetch
// and squash the wrong-path instruction in IF/ID, or fall through.
// Resolution statistics are kept in saturating counters.

module branch_seq_ctrl #(
    parameter int HOLD_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_branch,
    input  logic [15:0] id_instr,
    input  logic [15:0] id_pc_plus_two,
    input  logic        ex_wr_flags,
    input  logic [2:0]  flags,
    input  logic        err_clr,
    output logic        stall,
    output logic        pc_redirect,
    output logic [15:0] target_pc,
    output logic        flush_ifid,
    output logic        timeout_err,
    output logic [15:0] taken_cnt,
    output logic [15:0] nottaken_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIMIT_C = 8'(HOLD_LIMIT);

    state_t      state_q,        state_d;
    logic [7:0]  hold_cnt_q,     hold_cnt_d;
    logic [15:0] instr_q,        instr_d;
    logic [15:0] pc_q,           pc_d;
    logic        timeout_err_q,  timeout_err_d;
    logic [15:0] taken_cnt_q,    taken_cnt_d;
    logic [15:0] nottaken_cnt_q, nottaken_cnt_d;

    logic [15:0] sel_instr;
    logic [15:0] sel_pc;
    logic [15:0] sext_off;
    logic [15:0] target_calc;
    logic        resolve;
    logic        force_not_taken;
    logic        timeout_set;
    logic        take;

    // The top two opcode bits carry no meaning for the sequencer.
    logic unused_instr_bits;
    assign unused_instr_bits = ^id_instr[15:14];

    // Flag order is {N,V,Z}; codes 110 and 111 are reserved and never taken.
    function automatic logic cond_met(input logic [2:0] cc, input logic [2:0] fl);
        logic n;
        logic v;
        logic z;
        n = fl[2];
        v = fl[1];
        z = fl[0];
        case (cc)
            3'b000:  cond_met = !z;
            3'b001:  cond_met = z;
            3'b010:  cond_met = v;
            3'b011:  cond_met = !v;
            3'b100:  cond_met = n & !z;
            3'b101:  cond_met = !n & !z;
            default: cond_met = 1'b0;
        endcase
    endfunction

    // While holding, the IF/ID register may already show other contents, so
    // resolution works from the copy latched when the hold started; from IDLE
    // the live decode inputs are used. The offset is added unshifted and the
    // sum simply wraps at 16 bits.
    always_comb begin
        sel_instr   = (state_q == HOLD) ? instr_q : id_instr;
        sel_pc      = (state_q == HOLD) ? pc_q    : id_pc_plus_two;
        sext_off    = {{5{sel_instr[10]}}, sel_instr[10:0]};
        target_calc = sel_pc + sext_off;
    end

    // Sequencer next-state and outputs. Every path defaults to "nothing
    // happens"; the state decodes pick a hold, a resolution or a flush, and a
    // common resolution step then decides taken/not-taken, bumps the right
    // counter and chooses FLUSH or IDLE. Reset forces all pulse outputs low
    // in the cycle it is asserted so no redirect or flush escapes an abort.
    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        instr_d         = instr_q;
        pc_d            = pc_q;
        taken_cnt_d     = taken_cnt_q;
        nottaken_cnt_d  = nottaken_cnt_q;
        stall           = 1'b0;
        pc_redirect     = 1'b0;
        target_pc       = 16'h0000;
        flush_ifid      = 1'b0;
        resolve         = 1'b0;
        force_not_taken = 1'b0;
        timeout_set     = 1'b0;
        take            = 1'b0;

        case (state_q)
            IDLE: begin
                if (id_branch) begin
                    if (ex_wr_flags) begin
                        stall      = 1'b1;
                        instr_d    = id_instr;
                        pc_d       = id_pc_plus_two;
                        hold_cnt_d = 8'd1;
                        state_d    = HOLD;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (ex_wr_flags) begin
                    if (hold_cnt_q < HOLD_LIMIT_C) begin
                        stall      = 1'b1;
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end else begin
                        timeout_set     = 1'b1;
                        force_not_taken = 1'b1;
                        resolve         = 1'b1;
                    end
                end else begin
                    resolve = 1'b1;
                end
            end
            FLUSH: begin
                flush_ifid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (resolve) begin
            take       = !force_not_taken && cond_met(sel_instr[13:11], flags);
            hold_cnt_d = 8'd0;
            if (take) begin
                pc_redirect = 1'b1;
                target_pc   = target_calc;
                taken_cnt_d = (taken_cnt_q == 16'hFFFF) ? taken_cnt_q : taken_cnt_q + 16'd1;
                state_d     = FLUSH;
            end else begin
                nottaken_cnt_d = (nottaken_cnt_q == 16'hFFFF) ? nottaken_cnt_q : nottaken_cnt_q + 16'd1;
                state_d        = IDLE;
            end
        end

        if (rst) begin
            stall       = 1'b0;
            pc_redirect = 1'b0;
            target_pc   = 16'h0000;
            flush_ifid  = 1'b0;
        end
    end

    // Sticky timeout error: a new timeout beats a simultaneous clear so the
    // event can never be lost.
    always_comb begin
        timeout_err_d = timeout_err_q;
        if (timeout_set) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end
    end

    // State, latches and counters; reset is synchronous and overrides
    // whatever the next-state logic computed this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            hold_cnt_q     <= 8'd0;
            instr_q        <= 16'h0000;
            pc_q           <= 16'h0000;
            timeout_err_q  <= 1'b0;
            taken_cnt_q    <= 16'h0000;
            nottaken_cnt_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            instr_q        <= instr_d;
            pc_q           <= pc_d;
            timeout_err_q  <= timeout_err_d;
            taken_cnt_q    <= taken_cnt_d;
            nottaken_cnt_q <= nottaken_cnt_d;
        end
    end

    // Registered status outputs.
    always_comb begin
        timeout_err  = timeout_err_q;
        taken_cnt    = taken_cnt_q;
        nottaken_cnt = nottaken_cnt_q;
    end

endmodule
